// File: rtl/naneye_tx_emulator.sv
`default_nettype none
// ============================================================================
// naneye_tx_emulator : Manchester-encoded NanEye video link transmitter model
// Optional macro TEST_PATTERN_EN adds PATTERN_SEL and a (row+col) pattern.
// Revision: 1.0
// ============================================================================
module naneye_tx_emulator #(
  parameter int C_ROWS          = 320,
  parameter int C_COLUMNS       = 320,
  parameter int D_WIDTH         = 10,
  parameter int HALF_BIT_CLKS   = 4,
  parameter int FRAME_SYNC_BITS = 16,
  parameter int LINE_SYNC_BITS  = 4
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               START,
  output logic               DATA_REQ,
  input  logic [D_WIDTH-1:0] DATA_IN,
  output logic               TX_DAT,
  output logic               TX_OE,
  output logic               BUSY,
  output logic               LINE_END,
`ifdef TEST_PATTERN_EN
  input  logic               PATTERN_SEL,
`endif
  output logic               FRAME_DONE
);

  localparam int WORD_BITS = D_WIDTH + 2;
  localparam int SYNC_MAX  = (FRAME_SYNC_BITS > LINE_SYNC_BITS) ? FRAME_SYNC_BITS : LINE_SYNC_BITS;
  localparam int BIT_MAX   = (SYNC_MAX > WORD_BITS) ? SYNC_MAX : WORD_BITS;
  localparam int BW        = $clog2(BIT_MAX);
  localparam int HBW       = $clog2(HALF_BIT_CLKS);
  localparam int CW        = $clog2(C_COLUMNS + 1);
  localparam int RW        = $clog2(C_ROWS + 1);
  localparam logic [HBW-1:0] HB_LAST = HBW'(HALF_BIT_CLKS - 1);
  localparam logic [HBW-1:0] HB_PRE  = HBW'(HALF_BIT_CLKS - 2);

  typedef enum logic [1:0] {S_IDLE, S_FSYNC, S_LSYNC, S_PIXEL} state_t;

  state_t             state_q, state_d;
  logic [HBW-1:0]     hb_q, hb_d;
  logic               half_q, half_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [D_WIDTH-1:0] shift_q, shift_d;
  logic               tx_dat_q, tx_dat_d, tx_oe_q, tx_oe_d, busy_q, busy_d;
  logic               data_req_q, data_req_d, line_end_q, line_end_d;
  logic               frame_done_q, frame_done_d, eol_q, eol_d, eof_q, eof_d;
  logic               last_bit, hb_end, bit_end, seg_end, col_last, row_last, cur_bit;
  logic [D_WIDTH-1:0] pixel_val;

`ifdef TEST_PATTERN_EN
  logic pattern_q, pattern_d;
  assign pixel_val = pattern_q ? (D_WIDTH'(row_q) + D_WIDTH'(col_q)) : DATA_IN;
`else
  assign pixel_val = DATA_IN;
`endif

  assign hb_end   = (hb_q == HB_LAST);
  assign bit_end  = hb_end && half_q;
  assign seg_end  = bit_end && last_bit;
  assign col_last = (col_q == CW'(C_COLUMNS - 1));
  assign row_last = (row_q == RW'(C_ROWS - 1));

  // The FSM runs one cycle ahead of the registered line: state in cycle k sets TX_DAT for k+1.
  always_comb begin
    state_d      = state_q;
    hb_d         = hb_q;
    half_d       = half_q;
    bit_d        = bit_q;
    col_d        = col_q;
    row_d        = row_q;
    shift_d      = shift_q;
    eol_d        = 1'b0;
    eof_d        = 1'b0;
    line_end_d   = eol_q;
    frame_done_d = eof_q;
`ifdef TEST_PATTERN_EN
    pattern_d    = pattern_q;
`endif

    case (state_q)
      S_FSYNC: last_bit = (bit_q == BW'(FRAME_SYNC_BITS - 1));
      S_LSYNC: last_bit = (bit_q == BW'(LINE_SYNC_BITS - 1));
      default: last_bit = (bit_q == BW'(WORD_BITS - 1));
    endcase

    if (bit_q == '0)                    cur_bit = 1'b1;
    else if (bit_q == BW'(WORD_BITS-1)) cur_bit = 1'b0;
    else                                cur_bit = shift_q[D_WIDTH-1];

    case (state_q)
      S_FSYNC: tx_dat_d = 1'b1;
      S_PIXEL: tx_dat_d = cur_bit ^ half_q;
      default: tx_dat_d = 1'b0;
    endcase
    tx_oe_d = (state_q != S_IDLE);

    // Request lands two cycles before the next word's first half-bit on the line.
    data_req_d = last_bit && half_q && (hb_q == HB_PRE) &&
                 ((state_q == S_LSYNC) || ((state_q == S_PIXEL) && !col_last));

    if (state_q == S_IDLE) begin
      hb_d   = '0;
      half_d = 1'b0;
      bit_d  = '0;
      col_d  = '0;
      row_d  = '0;
      if (START && !busy_q && !frame_done_q) begin
        state_d = S_FSYNC;
`ifdef TEST_PATTERN_EN
        pattern_d = PATTERN_SEL;
`endif
      end
    end else begin
      if (hb_end) begin
        hb_d   = '0;
        half_d = ~half_q;
      end else begin
        hb_d = hb_q + 1'b1;
      end
      if (bit_end) bit_d = bit_q + 1'b1;

      if (state_q == S_PIXEL) begin
        if ((hb_q == '0) && !half_q && (bit_q == '0)) shift_d = pixel_val;
        else if (bit_end && (bit_q != '0))             shift_d = shift_q << 1;
      end

      if (seg_end) begin
        bit_d = '0;
        case (state_q)
          S_FSYNC: state_d = S_LSYNC;
          S_LSYNC: state_d = S_PIXEL;
          default: begin
            if (col_last) begin
              col_d = '0;
              eol_d = 1'b1;
              if (row_last) begin
                eof_d   = 1'b1;
                state_d = S_IDLE;
              end else begin
                row_d   = row_q + 1'b1;
                state_d = S_LSYNC;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        endcase
      end
    end

    // Covers the final line cycle after the FSM has already dropped to IDLE.
    busy_d = (state_q != S_IDLE) || (state_d != S_IDLE);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      hb_q         <= '0;
      half_q       <= 1'b0;
      bit_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      shift_q      <= '0;
      tx_dat_q     <= 1'b0;
      tx_oe_q      <= 1'b0;
      busy_q       <= 1'b0;
      data_req_q   <= 1'b0;
      line_end_q   <= 1'b0;
      frame_done_q <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
`ifdef TEST_PATTERN_EN
      pattern_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hb_q         <= hb_d;
      half_q       <= half_d;
      bit_q        <= bit_d;
      col_q        <= col_d;
      row_q        <= row_d;
      shift_q      <= shift_d;
      tx_dat_q     <= tx_dat_d;
      tx_oe_q      <= tx_oe_d;
      busy_q       <= busy_d;
      data_req_q   <= data_req_d;
      line_end_q   <= line_end_d;
      frame_done_q <= frame_done_d;
      eol_q        <= eol_d;
      eof_q        <= eof_d;
`ifdef TEST_PATTERN_EN
      pattern_q    <= pattern_d;
`endif
    end
  end

  assign TX_DAT     = tx_dat_q;
  assign TX_OE      = tx_oe_q;
  assign BUSY       = busy_q;
  assign DATA_REQ   = data_req_q;
  assign LINE_END   = line_end_q;
  assign FRAME_DONE = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_naneye_tx_emulator.sv
`default_nettype none
// ============================================================================
// tb_naneye_tx_emulator : bench for the NanEye link transmitter model
// Revision: 1.0
// ============================================================================
module tb_naneye_tx_emulator;

  localparam int R  = 2;
  localparam int C  = 3;
  localparam int H  = 2;
  localparam int FS = 8;
  localparam int LS = 4;
  localparam int DW = 10;
  localparam int BITP = 2 * H;
  localparam int LL   = (LS + 12 * C) * BITP;
  localparam int F    = (FS + R * (LS + 12 * C)) * BITP;

  logic          CLOCK, RESET, START;
  logic          DATA_REQ, TX_DAT, TX_OE, BUSY, LINE_END, FRAME_DONE;
  logic [DW-1:0] DATA_IN;
`ifdef TEST_PATTERN_EN
  logic          PATTERN_SEL;
`endif

  naneye_tx_emulator #(
    .C_ROWS(R), .C_COLUMNS(C), .D_WIDTH(DW), .HALF_BIT_CLKS(H),
    .FRAME_SYNC_BITS(FS), .LINE_SYNC_BITS(LS)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .DATA_REQ(DATA_REQ),
    .DATA_IN(DATA_IN), .TX_DAT(TX_DAT), .TX_OE(TX_OE), .BUSY(BUSY),
    .LINE_END(LINE_END),
`ifdef TEST_PATTERN_EN
    .PATTERN_SEL(PATTERN_SEL),
`endif
    .FRAME_DONE(FRAME_DONE)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int S = 0;
  bit running = 0;
  bit cmp_en  = 0;
  bit pat     = 0;
  logic [DW-1:0] pix [0:R*C-1];
  int k = 0;
  bit hold = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pixel_of(input int r, input int w);
    if (pat) return DW'((r + w) % (1 << DW));
    return pix[r * C + w];
  endfunction

  // Expected line level at line-cycle index j counted from the first TX_OE cycle.
  function automatic logic model_dat(input int j);
    int b, hf, bb, r, rem, w, kk;
    logic [11:0] word;
    logic v;
    b  = j / BITP;
    hf = (j / H) % 2;
    if (b < FS) return 1'b1;
    bb  = b - FS;
    r   = bb / (LS + 12 * C);
    rem = bb % (LS + 12 * C);
    if (rem < LS) return 1'b0;
    w    = (rem - LS) / 12;
    kk   = (rem - LS) % 12;
    word = {1'b1, pixel_of(r, w), 1'b0};
    v    = word[11 - kk];
    return (hf != 0) ? ~v : v;
  endfunction

  // Pixel source: value valid in the cycle after DATA_REQ, garbage otherwise.
  always @(negedge CLOCK) begin
    if (DATA_REQ === 1'b1) begin
      DATA_IN = pix[(k < R * C) ? k : R * C - 1];
      k++;
      hold = 1;
    end else if (hold) begin
      hold = 0;
    end else begin
      DATA_IN = DW'($urandom);
    end
  end

  // Directed-frame recording
  bit rec = 0, oe_seen = 0, busy_seen = 0;
  int t0 = 0, busy_rel = 0, fd_cnt = 0, fd_rel = 0, req_cnt = 0;
  int le_q[$];
  logic line_q[$];

  int n, m, mr;
  logic e_busy, e_oe, e_dat, e_le, e_fd, e_req;
  always @(posedge CLOCK) begin
    #1;
    if (cmp_en) begin
      n      = cyc - S;
      e_busy = running && n >= 1 && n <= F + 1;
      e_oe   = running && n >= 2 && n <= F + 1;
      e_dat  = e_oe ? model_dat(n - 2) : 1'b0;
      m      = n - 2 - FS * BITP;
      e_le   = running && m > 0 && (m % LL) == 0 && (m / LL) <= R;
      e_fd   = running && n == F + 2;
      m      = n - FS * BITP;
      mr     = (m >= 0) ? m % LL : 0;
      e_req  = running && m >= 0 && (m / LL) < R && mr >= LS * BITP &&
               ((mr - LS * BITP) % (24 * H)) == 0;
      chk("busy",       int'(BUSY),       int'(e_busy));
      chk("tx_oe",      int'(TX_OE),      int'(e_oe));
      chk("tx_dat",     int'(TX_DAT),     int'(e_dat));
      chk("line_end",   int'(LINE_END),   int'(e_le));
      chk("frame_done", int'(FRAME_DONE), int'(e_fd));
      chk("data_req",   int'(DATA_REQ),   int'(e_req));
      if (rec) begin
        if (BUSY && !busy_seen) begin busy_seen = 1; busy_rel = cyc - S; end
        if (TX_OE && !oe_seen)  begin oe_seen = 1;   t0 = cyc;         end
        if (TX_OE)      line_q.push_back(TX_DAT);
        if (LINE_END)   le_q.push_back(cyc - t0);
        if (FRAME_DONE) begin fd_cnt++; fd_rel = cyc - t0; end
        if (DATA_REQ)   req_cnt++;
      end
    end
  end

  task automatic new_pixels();
    for (int i = 0; i < R * C; i++) pix[i] = DW'($urandom);
  endtask

  task automatic start_frame();
    @(negedge CLOCK);
    START   = 1'b1;
    S       = cyc;
    running = 1;
    k       = 0;
`ifdef TEST_PATTERN_EN
    pat     = PATTERN_SEL;
`endif
    @(negedge CLOCK);
    START = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge CLOCK);
  endtask

  initial begin
    logic [11:0] dec;
    bit manch_ok;
    int base, i0;
    RESET   = 1'b1;
    START   = 1'b0;
    DATA_IN = '0;
`ifdef TEST_PATTERN_EN
    PATTERN_SEL = 1'b0;
`endif
    new_pixels();
    repeat (3) @(negedge CLOCK);
    chk("reset_busy",   int'(BUSY),   0);
    chk("reset_tx_dat", int'(TX_DAT), 0);
    RESET  = 1'b0;
    cmp_en = 1;
    repeat (4) @(negedge CLOCK);

    // Directed frame: first word 10'h2A5, timing pinned to literals.
    new_pixels();
    pix[0] = 10'h2A5;
    rec = 1;
    start_frame();
    wait_until(S + F + 6);
    rec = 0;
    chk("busy_rise_offset", busy_rel, 1);
    chk("oe_rise_offset",   t0 - S,   2);
    chk("line_end_count",   le_q.size(), 2);
    chk("line_end_0",       (le_q.size() > 0) ? le_q[0] : -1, 192);
    chk("line_end_1",       (le_q.size() > 1) ? le_q[1] : -1, 352);
    chk("frame_done_count", fd_cnt,  1);
    chk("frame_done_at",    fd_rel,  352);
    chk("data_req_count",   req_cnt, 6);
    chk("frame_oe_cycles",  line_q.size(), 352);
    base     = (FS + LS) * BITP;
    manch_ok = 1;
    dec      = '0;
    if (line_q.size() >= base + 12 * BITP) begin
      for (int b = 0; b < 12; b++) begin
        i0 = base + b * BITP;
        if (line_q[i0] != line_q[i0 + 1] || line_q[i0 + H] != line_q[i0 + H + 1] ||
            line_q[i0] == line_q[i0 + H]) manch_ok = 0;
        dec[11 - b] = line_q[i0];
      end
    end else begin
      manch_ok = 0;
    end
    chk("manchester_halfbits", int'(manch_ok), 1);
    chk("decoded_word",        int'(dec),      int'(12'hD4A));

    // START while busy, and START in the FRAME_DONE cycle, are both ignored.
    new_pixels();
    start_frame();
    wait_until(S + 100);
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    wait_until(S + F + 2);
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    repeat (12) @(negedge CLOCK);

    // Reset mid-frame
    new_pixels();
    start_frame();
    wait_until(S + 150);
    chk("oe_before_reset", int'(TX_OE), 1);
    RESET   = 1'b1;
    running = 0;
    #1;
    chk("rst_tx_dat",     int'(TX_DAT),     0);
    chk("rst_tx_oe",      int'(TX_OE),      0);
    chk("rst_busy",       int'(BUSY),       0);
    chk("rst_data_req",   int'(DATA_REQ),   0);
    chk("rst_line_end",   int'(LINE_END),   0);
    chk("rst_frame_done", int'(FRAME_DONE), 0);
    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;
    repeat (3) @(negedge CLOCK);

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      new_pixels();
`ifdef TEST_PATTERN_EN
      PATTERN_SEL = (f % 2 == 1);
`endif
      start_frame();
`ifdef TEST_PATTERN_EN
      PATTERN_SEL = 1'(!PATTERN_SEL);
`endif
      wait_until(S + F + 3);
      repeat ($urandom_range(1, 20)) @(negedge CLOCK);
    end

    repeat (5) @(negedge CLOCK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/naneye_tx_emulator.md
# naneye_tx_emulator

Transmit-side model of the NanEye sensor's serial video link. It generates the Manchester-encoded pixel stream that the receive path decodes and deserializes: frame sync, line sync, then 12-bit pixel words. The block sits in the lab/bring-up build, driving the receive pin directly or through a loopback, so the decoder, deserializer and line-period logic can be exercised without a sensor.

## Interface
Parameters:
- C_ROWS, 320, lines per frame
- C_COLUMNS, 320, pixel words per line
- D_WIDTH, 10, pixel data bits
- HALF_BIT_CLKS, 4, CLOCK cycles per Manchester half-bit (≥2)
- FRAME_SYNC_BITS, 16, bit periods of frame-sync high level
- LINE_SYNC_BITS, 4, bit periods of line-sync low level

Ports:
- CLOCK  in  1  single block clock
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle pulse; begins one frame when idle
- DATA_REQ  out  1  one-cycle pulse requesting the next pixel
- DATA_IN  in  D_WIDTH  pixel value, valid the cycle after DATA_REQ
- TX_DAT  out  1  serial line output (registered)
- TX_OE  out  1  high while a frame is being driven
- BUSY  out  1  high from accepted START until frame end
- LINE_END  out  1  one-cycle pulse after the last word of each line
- FRAME_DONE  out  1  one-cycle pulse after the last word of the frame
- PATTERN_SEL  in  1  only with TEST_PATTERN_EN; selects the internal pattern

## Operation
- Word format: start bit 1, D_WIDTH data bits MSB first, stop bit 0, so 12 bits for D_WIDTH=10.
- Manchester encoding: a 1 is sent high then low; a 0 is sent low then high. Each half-bit lasts HALF_BIT_CLKS cycles.
- State machine:
  - IDLE: TX_DAT=0, TX_OE=0. START moves to FSYNC.
  - FSYNC: TX_DAT held high for FRAME_SYNC_BITS bit periods, then go to LSYNC.
  - LSYNC: TX_DAT held low for LINE_SYNC_BITS bit periods, then go to PIXEL.
  - PIXEL: send C_COLUMNS words. After the last word, pulse LINE_END. If row < C_ROWS-1, go to LSYNC; otherwise pulse FRAME_DONE and go to IDLE.
- Counters:
  - Half-bit counter: 0..HALF_BIT_CLKS-1.
  - Bit counter: 0..11, or the sync length.
  - Column counter: 0..C_COLUMNS-1.
  - Row counter: 0..C_ROWS-1.
  - All counters clear on entry to IDLE.
- Data handshake: DATA_REQ pulses 2 cycles before the first half-bit of each word. DATA_IN is captured into the shift register exactly 1 cycle after DATA_REQ. There is no backpressure; DATA_IN must be valid then.
- START while BUSY is ignored, including START in the FRAME_DONE cycle.
- RESET at any point, including mid-word:
  - all outputs return to their reset values immediately;
  - the FSM returns to IDLE;
  - any partial frame is abandoned;
  - no FRAME_DONE pulse is issued.

## Timing
- Reset values: TX_DAT=0, TX_OE=0, BUSY=0, DATA_REQ=0, LINE_END=0, FRAME_DONE=0.
- START to BUSY: BUSY goes high the cycle after START is sampled.
- START to line activity: TX_OE and TX_DAT go high 2 cycles after START is sampled.
- Bit period: 2·HALF_BIT_CLKS cycles. Word period: 24·HALF_BIT_CLKS cycles. There is no gap between words in a line.
- Frame length: bits = FRAME_SYNC_BITS + C_ROWS·(LINE_SYNC_BITS + 12·C_COLUMNS). Cycles = that value × 2·HALF_BIT_CLKS.
- Pulse alignment: LINE_END and FRAME_DONE assert in the cycle after the final half-bit of the line's last stop bit.
- End of frame: BUSY and TX_OE deassert in the same cycle as FRAME_DONE. TX_DAT returns to 0 in that cycle.

## Configuration
- TEST_PATTERN_EN defined:
  - The PATTERN_SEL port exists.
  - With PATTERN_SEL=1, the pixel value is (row + column) mod 2^D_WIDTH and DATA_IN is ignored. DATA_REQ still pulses.
  - PATTERN_SEL is sampled only at START.
- TEST_PATTERN_EN undefined: the PATTERN_SEL port and the pattern logic are absent, and pixels always come from DATA_IN.

## Test plan
Parameters for all scenarios unless stated: C_ROWS=2, C_COLUMNS=3, HALF_BIT_CLKS=2, FRAME_SYNC_BITS=8, LINE_SYNC_BITS=4.
- Single frame: START pulse → BUSY high for 352 cycles; 6 DATA_REQ pulses; LINE_END at cycle 192 and at cycle 352; a single FRAME_DONE at cycle 352.
- Word encoding: DATA_IN=10'h2A5 → TX_DAT half-bits decode as 1, 1010100101, 0, each half-bit 2 cycles wide. Checked with a Manchester decoder on the bench.
- START while busy: second START at cycle 100 → ignored; total frame still 352 cycles; one FRAME_DONE.
- Reset mid-word: assert RESET at cycle 150 → TX_DAT=0, TX_OE=0, BUSY=0 immediately. After release, a new START produces a full 352-cycle frame.
- Loopback: run the emulator at 40 MHz-equivalent timing into the receive chain with C_ROWS=C_COLUMNS=320 → deserializer outputs a ramp matching DATA_IN; PIXEL_ERROR stays 0.
- With TEST_PATTERN_EN, PATTERN_SEL=1: row 1, column 2 word carries value 3; DATA_IN is ignored.
